// File: rtl/data_bus_watchdog.sv
// Single-outstanding data bus bridge. Forwards the core request to the peripheral
// and synthesises an error response when grant or rvalid never arrives.
module data_bus_watchdog #(
  parameter int unsigned GNT_TIMEOUT = 16,
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_data_req,
  input  logic        s_data_we,
  input  logic [3:0]  s_data_be,
  input  logic [31:0] s_data_addr,
  input  logic [31:0] s_data_wdata,
  output logic        s_data_gnt,
  output logic        s_data_rvalid,
  output logic        s_data_err,
  output logic [31:0] s_data_rdata,
  output logic        m_data_req,
  output logic        m_data_we,
  output logic [3:0]  m_data_be,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  input  logic        m_data_gnt,
  input  logic        m_data_rvalid,
  input  logic        m_data_err,
  input  logic [31:0] m_data_rdata,
  output logic [7:0]  err_count,
  output logic [31:0] last_err_addr
);

  typedef enum logic [1:0] {IDLE, WAIT_RSP, ERR_RSP, DRAIN} state_t;

  // Counter value seen in the last allowed cycle of each wait.
  localparam logic [15:0] GNT_LAST = 16'(GNT_TIMEOUT - 1);
  localparam logic [15:0] RSP_LAST = 16'(RSP_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] last_err_addr_q, last_err_addr_d;
  logic        err_evt;
  logic [31:0] err_addr;

  assign m_data_we     = s_data_we;
  assign m_data_be     = s_data_be;
  assign m_data_addr   = s_data_addr;
  assign m_data_wdata  = s_data_wdata;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    m_data_req    = 1'b0;
    s_data_gnt    = 1'b0;
    s_data_rvalid = 1'b0;
    s_data_err    = 1'b0;
    s_data_rdata  = '0;
    err_evt       = 1'b0;
    err_addr      = addr_q;

    case (state_q)
      IDLE: begin
        m_data_req = s_data_req;
        s_data_gnt = m_data_gnt;
        cnt_d      = (!s_data_req || m_data_gnt) ? 16'd0 : cnt_q + 16'd1;
        if (s_data_req && m_data_gnt) begin
          addr_d  = s_data_addr;
          state_d = WAIT_RSP;
          cnt_d   = '0;
        end else if (s_data_req && cnt_q == GNT_LAST) begin
          // Grant the core ourselves but keep the peripheral from seeing it.
          m_data_req = 1'b0;
          s_data_gnt = 1'b1;
          addr_d     = s_data_addr;
          err_evt    = 1'b1;
          err_addr   = s_data_addr;
          state_d    = ERR_RSP;
          cnt_d      = '0;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 16'd1;
        if (m_data_rvalid) begin
          s_data_rvalid = 1'b1;
          s_data_err    = m_data_err;
          s_data_rdata  = m_data_rdata;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (cnt_q == RSP_LAST) begin
          s_data_rvalid = 1'b1;
          s_data_err    = 1'b1;
          err_evt       = 1'b1;
          state_d       = DRAIN;
          cnt_d         = '0;
        end
      end
      ERR_RSP: begin
        s_data_rvalid = 1'b1;
        s_data_err    = 1'b1;
        state_d       = IDLE;
        cnt_d         = '0;
      end
      DRAIN: begin
        // A late rvalid belongs to the abandoned request and is swallowed.
        cnt_d = cnt_q + 16'd1;
        if (m_data_rvalid || cnt_q == RSP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    err_count_d     = (err_evt && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    last_err_addr_d = err_evt ? err_addr : last_err_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

endmodule

// File: tb/tb_data_bus_watchdog.sv
// Bench for data_bus_watchdog: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the bridge.
module tb_data_bus_watchdog;

  localparam int GNT_TO = 16;
  localparam int RSP_TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_data_req, s_data_we;
  logic [3:0]  s_data_be;
  logic [31:0] s_data_addr, s_data_wdata;
  logic        s_data_gnt, s_data_rvalid, s_data_err;
  logic [31:0] s_data_rdata;
  logic        m_data_req, m_data_we;
  logic [3:0]  m_data_be;
  logic [31:0] m_data_addr, m_data_wdata;
  logic        m_data_gnt, m_data_rvalid, m_data_err;
  logic [31:0] m_data_rdata;
  logic [7:0]  err_count;
  logic [31:0] last_err_addr;

  data_bus_watchdog #(.GNT_TIMEOUT(GNT_TO), .RSP_TIMEOUT(RSP_TO)) dut (
    .clk(clk), .rst(rst),
    .s_data_req(s_data_req), .s_data_we(s_data_we), .s_data_be(s_data_be),
    .s_data_addr(s_data_addr), .s_data_wdata(s_data_wdata),
    .s_data_gnt(s_data_gnt), .s_data_rvalid(s_data_rvalid), .s_data_err(s_data_err),
    .s_data_rdata(s_data_rdata),
    .m_data_req(m_data_req), .m_data_we(m_data_we), .m_data_be(m_data_be),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_gnt(m_data_gnt), .m_data_rvalid(m_data_rvalid), .m_data_err(m_data_err),
    .m_data_rdata(m_data_rdata),
    .err_count(err_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level view: which phase the single outstanding request is in.
  int          ungranted_run;
  bit          outstanding;
  int          resp_age;
  bit          draining;
  int          drain_age;
  bit          err_next;
  logic [31:0] txn_addr;
  int          mdl_errs;
  logic [31:0] mdl_last;

  logic        obs_gnt, obs_mreq, obs_rv, obs_err, exp_gnt;
  logic [31:0] obs_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ungranted_run = 0; outstanding = 0; resp_age = 0; draining = 0;
    drain_age = 0; err_next = 0; txn_addr = '0; mdl_errs = 0; mdl_last = '0;
  endtask

  task automatic bump_err(input logic [31:0] a);
    mdl_last = a;
    if (mdl_errs < 255) mdl_errs++;
  endtask

  task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic gnt, input logic rv, input logic er,
                       input logic [31:0] rd);
    logic e_gnt, e_mreq, e_rv, e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    s_data_req = req; s_data_we = we; s_data_be = be; s_data_addr = addr;
    s_data_wdata = wdata; m_data_gnt = gnt; m_data_rvalid = rv;
    m_data_err = er; m_data_rdata = rd;
    #2;
    e_gnt = 1'b0; e_mreq = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
    if (err_next) begin
      e_rv = 1'b1; e_err = 1'b1;
    end else if (outstanding) begin
      if (rv) begin
        e_rv = 1'b1; e_err = er; e_rd = rd;
      end else if (resp_age + 1 == RSP_TO) begin
        e_rv = 1'b1; e_err = 1'b1;
      end
    end else if (!draining) begin
      e_mreq = req; e_gnt = gnt;
      if (req && !gnt && ungranted_run + 1 == GNT_TO) begin
        e_mreq = 1'b0; e_gnt = 1'b1;
      end
    end
    chk("s_gnt", 32'(s_data_gnt), 32'(e_gnt));
    chk("m_req", 32'(m_data_req), 32'(e_mreq));
    chk("s_rvalid", 32'(s_data_rvalid), 32'(e_rv));
    chk("s_err", 32'(s_data_err), 32'(e_err));
    chk("s_rdata", s_data_rdata, e_rd);
    chk("m_we", 32'(m_data_we), 32'(we));
    chk("m_be", 32'(m_data_be), 32'(be));
    chk("m_addr", m_data_addr, addr);
    chk("m_wdata", m_data_wdata, wdata);
    chk("err_count", 32'(err_count), 32'(mdl_errs));
    chk("last_err_addr", last_err_addr, mdl_last);
    obs_gnt = s_data_gnt; obs_mreq = m_data_req; obs_rv = s_data_rvalid;
    obs_err = s_data_err; obs_rd = s_data_rdata; exp_gnt = e_gnt;
    // Advance the model by the clock edge that follows.
    if (err_next) begin
      err_next = 0;
    end else if (outstanding) begin
      resp_age++;
      if (rv) outstanding = 0;
      else if (resp_age == RSP_TO) begin
        outstanding = 0; draining = 1; drain_age = 0; bump_err(txn_addr);
      end
    end else if (draining) begin
      drain_age++;
      if (rv || drain_age == RSP_TO) draining = 0;
    end else if (req && gnt) begin
      outstanding = 1; resp_age = 0; txn_addr = addr; ungranted_run = 0;
    end else if (req) begin
      ungranted_run++;
      if (ungranted_run == GNT_TO) begin
        err_next = 1; ungranted_run = 0; bump_err(addr);
      end
    end else begin
      ungranted_run = 0;
    end
  endtask

  task automatic idle_cyc(input logic rv, input logic [31:0] rd);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rv, 1'b0, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_data_req = 0; s_data_we = 0; s_data_be = 0; s_data_addr = 0; s_data_wdata = 0;
    m_data_gnt = 0; m_data_rvalid = 0; m_data_err = 0; m_data_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic        pend, p_we, g, v;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wd;
  int          mode;

  initial begin
    rst = 1'b1;
    do_reset();

    // Reset values
    idle_cyc(1'b0, 32'h0);
    chk("reset_err_count", 32'(err_count), 32'h0);
    chk("reset_last_err_addr", last_err_addr, 32'h0);

    // Normal read
    cycle(1'b1, 1'b0, 4'hF, 32'h1000_0004, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("normal_gnt_c0", 32'(obs_gnt), 32'h1);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    chk("normal_rvalid_c1", 32'(obs_rv), 32'h1);
    chk("normal_rdata_c1", obs_rd, 32'h1234_5678);
    chk("normal_err_c1", 32'(obs_err), 32'h0);
    idle_cyc(1'b0, 32'h0);
    chk("normal_err_count", 32'(err_count), 32'h0);

    // Grant timeout
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1, 1'b0, 4'hF, 32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 14) chk("gto_gnt_c14", 32'(obs_gnt), 32'h0);
      if (c == 15) begin
        chk("gto_gnt_c15", 32'(obs_gnt), 32'h1);
        chk("gto_mreq_c15", 32'(obs_mreq), 32'h0);
      end
    end
    idle_cyc(1'b0, 32'h0);
    chk("gto_rvalid_c16", 32'(obs_rv), 32'h1);
    chk("gto_err_c16", 32'(obs_err), 32'h1);
    chk("gto_rdata_c16", obs_rd, 32'h0);
    chk("gto_err_count", 32'(err_count), 32'h1);
    chk("gto_last_err_addr", last_err_addr, 32'h4000_0010);

    // Response timeout and drain
    cycle(1'b1, 1'b0, 4'hF, 32'h5000_0020, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c < 16; c++) idle_cyc(1'b0, 32'h0);
    idle_cyc(1'b0, 32'h0);
    chk("rto_rvalid_c16", 32'(obs_rv), 32'h1);
    chk("rto_err_c16", 32'(obs_err), 32'h1);
    for (int c = 17; c < 20; c++) idle_cyc(1'b0, 32'h0);
    chk("rto_err_count", 32'(err_count), 32'h2);
    chk("rto_last_err_addr", last_err_addr, 32'h5000_0020);
    idle_cyc(1'b1, 32'hDEAD_BEEF);
    chk("rto_late_rvalid_c20", 32'(obs_rv), 32'h0);
    cycle(1'b1, 1'b1, 4'h3, 32'h5000_0024, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rto_next_gnt_c21", 32'(obs_gnt), 32'h1);
    idle_cyc(1'b1, 32'h0);
    chk("rto_next_rvalid", 32'(obs_rv), 32'h1);

    // Race: rvalid in the timeout cycle wins
    cycle(1'b1, 1'b0, 4'hF, 32'h6000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c < 16; c++) idle_cyc(1'b0, 32'h0);
    idle_cyc(1'b1, 32'hCAFE_F00D);
    chk("race_rvalid", 32'(obs_rv), 32'h1);
    chk("race_err", 32'(obs_err), 32'h0);
    chk("race_rdata", obs_rd, 32'hCAFE_F00D);
    idle_cyc(1'b0, 32'h0);
    chk("race_err_count", 32'(err_count), 32'h2);

    // Randomized traffic
    pend = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_wd = '0;
    for (int i = 0; i < 3000; i++) begin
      mode = (i / 250) % 3;
      if (!pend && $urandom_range(2) == 0) begin
        pend = 1'b1; p_we = 1'($urandom_range(1)); p_be = 4'($urandom);
        p_addr = $urandom; p_wd = $urandom;
      end
      g = (mode == 1) ? ($urandom_range(31) == 0) : ($urandom_range(3) != 0);
      v = (mode == 2) ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
      cycle(pend, p_we, p_be, p_addr, p_wd, g, v, 1'($urandom_range(1)), $urandom);
      if (pend && exp_gnt) pend = 1'b0;
    end
    for (int c = 0; c < 40; c++) idle_cyc(1'b0, 32'h0);

    // Saturation
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < 16; c++)
        cycle(1'b1, 1'b0, 4'hF, 32'h7000_0000 + 32'(k), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle_cyc(1'b0, 32'h0);
    end
    idle_cyc(1'b0, 32'h0);
    chk("sat_err_count", 32'(err_count), 32'd255);
    chk("sat_last_err_addr", last_err_addr, 32'h7000_0000 + 32'd299);

    // Asynchronous reset in WAIT_RSP
    cycle(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_cyc(1'b0, 32'h0);
    #1;
    rst = 1'b1; m_data_rvalid = 1'b1; m_data_gnt = 1'b1; s_data_req = 1'b1;
    #1;
    chk("arst_rvalid", 32'(s_data_rvalid), 32'h0);
    chk("arst_gnt", 32'(s_data_gnt), 32'h1);
    chk("arst_mreq", 32'(m_data_req), 32'h1);
    chk("arst_err_count", 32'(err_count), 32'h0);
    chk("arst_last_err_addr", last_err_addr, 32'h0);
    model_reset();
    @(negedge clk);
    s_data_req = 1'b0; m_data_gnt = 1'b0; m_data_rvalid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) idle_cyc(1'b1, 32'h1111_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
